// File: rtl/zjh_jk_reg_bank.sv
// Multi-channel JK register bank with JK/D/T/shift modes, per-channel set/clear
// overrides and a saturating change-event counter.
module zjh_jk_reg_bank #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] Set_N,
    input  logic [WIDTH-1:0] Clr_N,
    input  logic             Ser_In,
    input  logic             Cnt_Clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [CNT_W-1:0] Tog_Cnt,
    output logic             Tog_Flag
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] q_next;
    logic             chg;

    // Truncating the concatenation drops the MSB and also covers WIDTH=1 (Q <= Ser_In).
    always_comb begin
        shifted = WIDTH'({Q, Ser_In});
        q_next  = Q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!Clr_N[i]) begin
                q_next[i] = 1'b0;
            end else if (!Set_N[i]) begin
                q_next[i] = 1'b1;
            end else if (En) begin
                case (Mode)
                    2'b00:   q_next[i] = (J[i] & ~Q[i]) | (~K[i] & Q[i]);
                    2'b01:   q_next[i] = J[i];
                    2'b10:   q_next[i] = Q[i] ^ J[i];
                    default: q_next[i] = shifted[i];
                endcase
            end
        end
    end

    assign chg = (q_next != Q);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Q        <= RST_VAL;
            Tog_Cnt  <= '0;
            Tog_Flag <= 1'b0;
        end else begin
            Q        <= q_next;
            Tog_Flag <= chg;
            if (Cnt_Clr) begin
                Tog_Cnt <= '0;
            end else if (chg && !(&Tog_Cnt)) begin
                Tog_Cnt <= Tog_Cnt + 1'b1;
            end
        end
    end

    // Single inverter off the register output, so Q and Qn are never both high.
    assign Qn = ~Q;

endmodule

// File: tb/tb_zjh_jk_reg_bank.sv
// Bench for zjh_jk_reg_bank: directed scenarios plus random stimulus against a
// behavioural model; a second instance with CNT_W=2 exercises counter saturation.
module tb_zjh_jk_reg_bank;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j, k, set_n, clr_n;
    logic         ser_in, cnt_clr;

    logic [W-1:0] q, qn, q2, qn2;
    logic [7:0]   cnt;
    logic [1:0]   cnt2;
    logic         flag, flag2;

    int total = 0;
    int bad   = 0;

    int m_q    = 0;
    int m_cnt  = 0;
    int m_cnt2 = 0;
    int m_flag = 0;

    always #5 clk = ~clk;

    zjh_jk_reg_bank #(.WIDTH(W), .RST_VAL(4'b0000), .CNT_W(8)) dut (
        .Clk(clk), .Rst(rst), .En(en), .Mode(mode), .J(j), .K(k),
        .Set_N(set_n), .Clr_N(clr_n), .Ser_In(ser_in), .Cnt_Clr(cnt_clr),
        .Q(q), .Qn(qn), .Tog_Cnt(cnt), .Tog_Flag(flag)
    );

    zjh_jk_reg_bank #(.WIDTH(W), .RST_VAL(4'b0000), .CNT_W(2)) dut2 (
        .Clk(clk), .Rst(rst), .En(en), .Mode(mode), .J(j), .K(k),
        .Set_N(set_n), .Clr_N(clr_n), .Ser_In(ser_in), .Cnt_Clr(cnt_clr),
        .Q(q2), .Qn(qn2), .Tog_Cnt(cnt2), .Tog_Flag(flag2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: next state from the textual rules, using integer arithmetic.
    task automatic model_edge();
        int nq;
        int qi, ji, ki, bitv;
        if (!en) begin
            nq = m_q;
        end else if (mode == 2'd3) begin
            nq = (m_q * 2 + int'(ser_in)) % (1 << W);
        end else begin
            nq = 0;
            for (int i = 0; i < W; i++) begin
                qi = (m_q >> i) & 1;
                ji = int'(j[i]);
                ki = int'(k[i]);
                if (mode == 2'd0) begin
                    if (ji == 1 && ki == 1)      bitv = 1 - qi;
                    else if (ji == 1)            bitv = 1;
                    else if (ki == 1)            bitv = 0;
                    else                         bitv = qi;
                end else if (mode == 2'd1) begin
                    bitv = ji;
                end else begin
                    bitv = (qi + ji) % 2;
                end
                nq = nq + (bitv << i);
            end
        end
        for (int i = 0; i < W; i++) begin
            if (!clr_n[i])      nq = nq & ~(1 << i);
            else if (!set_n[i]) nq = nq | (1 << i);
        end
        m_flag = (nq != m_q) ? 1 : 0;
        if (cnt_clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (m_flag == 1) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3)  m_cnt2++;
        end
        m_q = nq;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_q"},     32'(q),     32'(m_q));
        chk({tag, "_qn"},    32'(qn),    32'((~m_q) & 15));
        chk({tag, "_cnt"},   32'(cnt),   32'(m_cnt));
        chk({tag, "_flag"},  32'(flag),  32'(m_flag));
        chk({tag, "_cnt2"},  32'(cnt2),  32'(m_cnt2));
        chk({tag, "_flag2"}, 32'(flag2), 32'(m_flag));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; j = '0; k = '0;
        set_n = 4'hF; clr_n = 4'hF; ser_in = 1'b0; cnt_clr = 1'b0;
        #12;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qn", 32'(qn), 32'hF);
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_flag", 32'(flag), 32'h0);
        rst = 1'b0;

        // Asynchronous reset between edges while Q=1010
        en = 1'b1; mode = 2'd1; j = 4'b1010;
        step("t1_load");
        chk("t1_pre", 32'(q), 32'b1010);
        #3 rst = 1'b1;
        #1;
        chk("t1_q", 32'(q), 32'h0);
        chk("t1_qn", 32'(qn), 32'hF);
        chk("t1_cnt", 32'(cnt), 32'h0);
        chk("t1_flag", 32'(flag), 32'h0);
        m_q = 0; m_cnt = 0; m_cnt2 = 0; m_flag = 0;
        #1 rst = 1'b0;

        // JK mode
        mode = 2'd0; j = 4'b1010; k = 4'b0110;
        step("t2_e1");
        chk("t2_e1_const", 32'(q), 32'b1010);
        chk("t2_e1_flag_c", 32'(flag), 32'h1);
        step("t2_e2");
        chk("t2_e2_const", 32'(q), 32'b1000);
        chk("t2_e2_flag_c", 32'(flag), 32'h1);
        chk("t2_cnt_c", 32'(cnt), 32'd2);

        // Shift mode
        mode = 2'd3; ser_in = 1'b1;
        step("t3_e1");
        chk("t3_e1_q", 32'(q), 32'b0001);
        chk("t3_e1_qn", 32'(qn), 32'b1110);
        step("t3_e2");
        chk("t3_e2_q", 32'(q), 32'b0011);
        chk("t3_e2_qn", 32'(qn), 32'b1100);

        // Set/clear with En=0; clear wins
        mode = 2'd1; j = 4'b0110;
        step("t4_load");
        en = 1'b0; set_n = 4'b1110; clr_n = 4'b0111;
        step("t4_e1");
        chk("t4_e1_q", 32'(q), 32'b0111);
        clr_n = 4'b1110;
        step("t4_e2");
        chk("t4_e2_q", 32'(q), 32'b0110);

        // Counter clear with no change, then saturation on the 2-bit counter
        set_n = 4'hF; clr_n = 4'hF; en = 1'b1; mode = 2'd1; j = 4'b0110; cnt_clr = 1'b1;
        step("t6_d_hold");
        chk("t6_flag_c", 32'(flag), 32'h0);
        cnt_clr = 1'b0; mode = 2'd2; j = 4'b0001;
        for (int n = 1; n <= 5; n++) begin
            step($sformatf("t5_e%0d", n));
            chk($sformatf("t5_e%0d_cnt2_c", n), 32'(cnt2), (n < 3) ? 32'(n) : 32'd3);
        end
        cnt_clr = 1'b1;
        step("t5_clr");
        chk("t5_clr_cnt2", 32'(cnt2), 32'h0);
        chk("t5_clr_flag", 32'(flag2), 32'h1);
        cnt_clr = 1'b0;

        // Hold cases: D with J=Q, and En=0 with no overrides
        mode = 2'd1; j = q;
        step("t6_d");
        chk("t6_d_flag", 32'(flag), 32'h0);
        en = 1'b0; mode = 2'd2; j = 4'hF;
        step("t6_en0");
        chk("t6_en0_flag", 32'(flag), 32'h0);

        // Random stimulus
        for (int n = 0; n < 300; n++) begin
            en      = ($urandom_range(0, 7) != 0);
            mode    = 2'($urandom_range(0, 3));
            j       = 4'($urandom);
            k       = 4'($urandom);
            ser_in  = 1'($urandom);
            set_n   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            clr_n   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            cnt_clr = ($urandom_range(0, 15) == 0);
            step($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
